// File: rtl/oled_line_arbiter.sv
// Round-robin arbiter that streams one latched 16-character line per grant to the
// OLED controller's char-write port, then issues a single non-clearing update.
module oled_line_arbiter #(
  parameter int N_REQ      = 2,
  parameter int LINE_CHARS = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_REQ-1:0]               req,
  input  logic [2*N_REQ-1:0]             req_row,
  input  logic [8*LINE_CHARS*N_REQ-1:0]  req_text,
  output logic [N_REQ-1:0]               done,
  output logic                           busy,
  output logic                           write_start,
  output logic [8:0]                     write_base_addr,
  output logic [7:0]                     write_ascii_data,
  input  logic                           write_ready,
  output logic                           update_start,
  output logic                           update_clear,
  input  logic                           update_ready
);

  localparam int TW   = 8 * LINE_CHARS;
  localparam int CW   = $clog2(LINE_CHARS);
  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_CHARS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_UPD_ISSUE,
    S_UPD_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [IDXW-1:0] win_q, win_d;
  logic [1:0]      row_q, row_d;
  logic [TW-1:0]   text_q, text_d;
  logic [CW-1:0]   col_q, col_d;
  logic [8:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            seen_low_q, seen_low_d;
  logic            wstart_q, wstart_d;
  logic            ustart_q, ustart_d;
  logic            busy_q, busy_d;

  logic            found;
  int unsigned     pick;
  logic [CW-1:0]   col_nx;

  // Character 0 sits in the most significant byte of the line.
  function automatic logic [7:0] char_at(input logic [TW-1:0] t, input logic [CW-1:0] c);
    return t[(LINE_CHARS - 1 - int'(c)) * 8 +: 8];
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned idx;
      idx = (32'(rr_q) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    row_d      = row_q;
    text_d     = text_q;
    col_d      = col_q;
    addr_d     = addr_q;
    data_d     = data_q;
    seen_low_d = seen_low_q;
    busy_d     = busy_q;
    wstart_d   = 1'b0;
    ustart_d   = 1'b0;
    col_nx     = col_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (found && write_ready) begin
          win_d   = IDXW'(pick);
          row_d   = req_row[2*pick +: 2];
          text_d  = req_text[TW*pick +: TW];
          rr_d    = IDXW'((pick + 1) % N_REQ);
          busy_d  = 1'b1;
          col_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        addr_d  = {row_q, col_q, 3'b000};
        data_d  = char_at(text_q, col_q);
        state_d = S_WR_ISSUE;
      end
      S_WR_ISSUE: begin
        if (write_ready) begin
          wstart_d   = 1'b1;
          seen_low_d = 1'b0;
          state_d    = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        // A ready still high next to the strobe is stale; require a low first.
        if (!write_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          if (col_q == LAST_COL) begin
            state_d = S_UPD_ISSUE;
          end else begin
            col_d   = col_nx;
            addr_d  = {row_q, col_nx, 3'b000};
            data_d  = char_at(text_q, col_nx);
            state_d = S_WR_ISSUE;
          end
        end
      end
      S_UPD_ISSUE: begin
        if (update_ready) begin
          ustart_d   = 1'b1;
          seen_low_d = 1'b0;
          state_d    = S_UPD_WAIT;
        end
      end
      S_UPD_WAIT: begin
        if (!update_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      row_q      <= '0;
      text_q     <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      seen_low_q <= 1'b0;
      wstart_q   <= 1'b0;
      ustart_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      row_q      <= row_d;
      text_q     <= text_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      seen_low_q <= seen_low_d;
      wstart_q   <= wstart_d;
      ustart_q   <= ustart_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    done = '0;
    if (state_q == S_DONE) done[win_q] = 1'b1;
  end

  assign busy             = busy_q;
  assign write_start      = wstart_q;
  assign write_base_addr  = addr_q;
  assign write_ascii_data = data_q;
  assign update_start     = ustart_q;
  assign update_clear     = 1'b0;

endmodule

// File: tb/tb_oled_line_arbiter.sv
// Directed bench for oled_line_arbiter: behavioural OLED controller model plus
// table-driven single-line transfers and hand-written arbitration/reset corner cases.
module tb_oled_line_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   req;
  logic [3:0]   req_row;
  logic [255:0] req_text;
  logic [1:0]   done;
  logic         busy;
  logic         write_start;
  logic [8:0]   write_base_addr;
  logic [7:0]   write_ascii_data;
  logic         write_ready;
  logic         update_start;
  logic         update_clear;
  logic         update_ready;

  oled_line_arbiter #(.N_REQ(2), .LINE_CHARS(16)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req              (req),
    .req_row          (req_row),
    .req_text         (req_text),
    .done             (done),
    .busy             (busy),
    .write_start      (write_start),
    .write_base_addr  (write_base_addr),
    .write_ascii_data (write_ascii_data),
    .write_ready      (write_ready),
    .update_start     (update_start),
    .update_clear     (update_clear),
    .update_ready     (update_ready)
  );

  always #5 clk = ~clk;

  int unsigned nchk = 0;
  int unsigned nfail = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Controller model: after each strobe, ready stays high for *_hold cycles, then low *_low cycles.
  int unsigned wr_hold = 1, wr_low = 4, upd_low = 3;
  int unsigned wh = 0, wl = 0, ul = 0;
  logic        upd_block = 1'b0;
  logic        prev_ws = 1'b0, prev_us = 1'b0;
  logic        done_seen = 1'b0;
  int unsigned wcount = 0, ucount = 0;
  logic [8:0]  cap_addr [0:31];
  logic [7:0]  cap_data [0:31];

  initial begin
    write_ready  = 1'b1;
    update_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (done != 2'b00) done_seen = 1'b1;
    if (write_start) begin
      chk("wr_ctrl_idle", 32'(wh == 0 && wl == 0), 1);
      chk("wr_us_overlap", 32'(update_start), 0);
      chk("wr_consec", 32'(prev_ws), 0);
      if (wcount < 32) begin
        cap_addr[wcount] = write_base_addr;
        cap_data[wcount] = write_ascii_data;
      end
      wcount++;
      wh = wr_hold;
      wl = wr_low;
    end
    if (wh > 0) begin
      wh--;
      write_ready = 1'b1;
    end else if (wl > 0) begin
      wl--;
      write_ready = 1'b0;
    end else begin
      write_ready = 1'b1;
    end

    if (update_start) begin
      chk("upd_ctrl_idle", 32'(ul == 0 && !upd_block), 1);
      chk("upd_clear", 32'(update_clear), 0);
      chk("upd_consec", 32'(prev_us), 0);
      ucount++;
      ul = upd_low;
    end
    if (upd_block) begin
      update_ready = 1'b0;
    end else if (ul > 0) begin
      ul--;
      update_ready = 1'b0;
    end else begin
      update_ready = 1'b1;
    end
    prev_ws = write_start;
    prev_us = update_start;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(output logic [1:0] d);
    int unsigned n = 0;
    d = 2'b00;
    while (n < 3000) begin
      tick();
      if (done != 2'b00) begin
        d = done;
        break;
      end
      n++;
    end
    if (d == 2'b00) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_writes(input int unsigned target);
    int unsigned n = 0;
    while (wcount < target && n < 3000) begin
      tick();
      n++;
    end
    if (wcount < target) chk("write_timeout", wcount, target);
  endtask

  task automatic check_line(input logic [1:0] row, input logic [127:0] txt);
    logic [8:0] ea;
    logic [7:0] ed;
    chk("write_count", wcount, 16);
    chk("update_count", ucount, 1);
    for (int c = 0; c < 16; c++) begin
      ea = {row, 4'(c), 3'b000};
      ed = txt[(15 - c) * 8 +: 8];
      chk("wr_addr", 32'(cap_addr[c]), 32'(ea));
      chk("wr_data", 32'(cap_data[c]), 32'(ed));
    end
  endtask

  task automatic clear_caps();
    wcount = 0;
    ucount = 0;
  endtask

  typedef struct {
    logic [1:0]   req;
    logic [1:0]   row;
    logic [127:0] text;
    int unsigned  hold;
    int unsigned  low;
    logic [1:0]   exp_done;
  } vec_t;

  vec_t vecs [4];

  logic [1:0]   d;
  logic [127:0] t0, t1;
  int unsigned  who;

  initial begin
    vecs[0] = '{req: 2'b01, row: 2'd2, text: "  AstroPix3 FW  ", hold: 1, low: 4,  exp_done: 2'b01};
    vecs[1] = '{req: 2'b10, row: 2'd0, text: "Hello, OLED! 123", hold: 0, low: 1,  exp_done: 2'b10};
    vecs[2] = '{req: 2'b01, row: 2'd3, text: "ABCDEFGHIJKLMNOP", hold: 2, low: 10, exp_done: 2'b01};
    vecs[3] = '{req: 2'b10, row: 2'd1, text: "0123456789abcdef", hold: 0, low: 3,  exp_done: 2'b10};

    rstn     = 1'b0;
    req      = 2'b00;
    req_row  = '0;
    req_text = '0;
    repeat (3) tick();
    chk("rst_outputs", 32'({done, busy, write_start, update_start, update_clear,
                            write_base_addr, write_ascii_data}), 0);
    rstn = 1'b1;
    tick();

    // Single-requester line transfers under different controller timings.
    for (int i = 0; i < 4; i++) begin
      who = (vecs[i].req == 2'b10) ? 1 : 0;
      req_row[2*who +: 2]    = vecs[i].row;
      req_text[128*who +: 128] = vecs[i].text;
      wr_hold = vecs[i].hold;
      wr_low  = vecs[i].low;
      clear_caps();
      req = vecs[i].req;
      wait_done(d);
      req = 2'b00;
      chk("done_vec", 32'(d), 32'(vecs[i].exp_done));
      chk("busy_at_done", 32'(busy), 1);
      check_line(vecs[i].row, vecs[i].text);
      if (i == 0) begin
        chk("t1_addr_first", 32'(cap_addr[0]), 32'h100);
        chk("t1_addr_last", 32'(cap_addr[15]), 32'h178);
        chk("t1_data_col2", 32'(cap_data[2]), 32'h41);
        chk("t1_data_col0", 32'(cap_data[0]), 32'h20);
      end
      tick();
      chk("busy_after_done", 32'(busy), 0);
      chk("done_one_cycle", 32'(done), 0);
    end

    // Simultaneous requests from reset, then requester 0 re-arms while 1 is pending.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    wr_hold = 0;
    wr_low  = 1;
    t0 = "Requester zero !";
    t1 = "Requester one  !";
    req_row  = {2'd3, 2'd1};
    req_text = {t1, t0};
    clear_caps();
    req = 2'b11;
    wait_done(d);
    req = 2'b10;
    chk("rr_first", 32'(d), 32'b01);
    check_line(2'd1, t0);
    clear_caps();
    tick();
    req = 2'b11;
    wait_done(d);
    req = 2'b01;
    chk("rr_second", 32'(d), 32'b10);
    check_line(2'd3, t1);
    clear_caps();
    wait_done(d);
    req = 2'b00;
    chk("rr_third", 32'(d), 32'b01);
    check_line(2'd1, t0);
    tick();

    // Reset after the 7th strobe abandons the line; a held request restarts it at column 0.
    wr_hold = 1;
    wr_low  = 2;
    t0 = "Reset-test line!";
    req_row[1:0]    = 2'd0;
    req_text[127:0] = t0;
    clear_caps();
    done_seen = 1'b0;
    req = 2'b01;
    wait_writes(7);
    rstn = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({done, busy, write_start, update_start, update_clear,
                                  write_base_addr, write_ascii_data}), 0);
    repeat (3) tick();
    chk("rst_no_done", 32'(done_seen), 0);
    chk("rst_writes_abandoned", wcount, 7);
    clear_caps();
    rstn = 1'b1;
    wait_done(d);
    req = 2'b00;
    chk("restart_done", 32'(d), 32'b01);
    check_line(2'd0, t0);
    tick();

    // update_ready held low for 50 cycles once the line is written.
    wr_hold = 0;
    wr_low  = 1;
    upd_block = 1'b1;
    t0 = "Update wait 50cy";
    req_row[1:0]    = 2'd2;
    req_text[127:0] = t0;
    clear_caps();
    done_seen = 1'b0;
    req = 2'b01;
    wait_writes(16);
    repeat (50) tick();
    chk("upd_held_off", ucount, 0);
    chk("upd_no_early_done", 32'(done_seen), 0);
    chk("upd_busy_held", 32'(busy), 1);
    upd_block = 1'b0;
    wait_done(d);
    req = 2'b00;
    chk("upd_done", 32'(d), 32'b01);
    check_line(2'd2, t0);
    tick();

    // Requester 1 drops req and changes its inputs mid-line.
    wr_hold = 1;
    wr_low  = 2;
    t1 = "Original text #1";
    req_row[3:2]      = 2'd3;
    req_text[255:128] = t1;
    clear_caps();
    req = 2'b10;
    wait_writes(5);
    req = 2'b00;
    req_text[255:128] = "CHANGED CHANGED!";
    req_row[3:2]      = 2'd0;
    wait_done(d);
    chk("drop_done", 32'(d), 32'b10);
    check_line(2'd3, t1);
    tick();
    chk("drop_idle_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
